// File: rtl/generic_bus_mem_responder_pkg.sv
// Shared types and address helpers for the generic-bus memory responder.
package generic_bus_resp_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  typedef logic [31:0] word_t;

  // Word index relative to the base; an address below the base wraps to a huge index.
  function automatic word_t word_index(word_t addr, word_t base);
    return (addr - base) >> 2;
  endfunction

  function automatic logic index_in_range(word_t idx, word_t depth);
    return idx < depth;
  endfunction

endpackage

// File: rtl/generic_bus_mem_responder_if.sv
// Generic bus between the core's initiator and the memory responder.
interface generic_bus_mem_responder_if
  import generic_bus_resp_pkg::*;
();
  logic       ren;
  logic       wen;
  word_t      addr;
  word_t      wdata;
  logic [3:0] byte_en;
  logic       busy;
  word_t      rdata;
  logic       error;

  modport master (output ren, wen, addr, wdata, byte_en, input busy, rdata, error);
  modport slave  (input ren, wen, addr, wdata, byte_en, output busy, rdata, error);
endinterface

// File: rtl/generic_bus_mem_responder_mem_array.sv
// Word storage: byte-lane synchronous write, combinational read. Not reset.
module generic_bus_mem_array
  import generic_bus_resp_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned AW          = $clog2(DEPTH_WORDS)
) (
  input  logic          CLK,
  input  logic          we,
  input  logic [AW-1:0] idx,
  input  word_t         wdata,
  input  logic [3:0]    byte_en,
  output word_t         rdata
);

  word_t mem_q [DEPTH_WORDS];

  // Commit enabled lanes of the write word on the clock edge.
  always_ff @(posedge CLK) begin
    if (we) begin
      for (int i = 0; i < 4; i++) begin
        if (byte_en[i]) mem_q[idx][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  assign rdata = mem_q[idx];

endmodule

// File: rtl/generic_bus_mem_responder.sv
// Generic-bus responder backed by an internal word memory with fixed wait states.
//
//   state | meaning
//   IDLE  | waiting for ren/wen; request latched on acceptance
//   WAIT  | counting wait states; both requests dropped aborts
//   RESP  | completion cycle: busy=0, write commits at end of cycle
module generic_bus_mem_responder
  import generic_bus_resp_pkg::*;
#(
  parameter word_t       BASE_ADDR   = 32'h8000_0000,
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned WAIT_STATES = 2
) (
  input logic                        CLK,
  input logic                        nRST,
  generic_bus_mem_responder_if.slave bus
);

  localparam int unsigned AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  state_e        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [AW-1:0] idx_q, idx_d;
  word_t         wdata_q, wdata_d;
  logic [3:0]    be_q, be_d;
  logic          wr_q, wr_d;
  logic          err_q, err_d;

  word_t req_idx;
  logic  req_err;
  logic  mem_we;
  word_t mem_rdata;

  assign req_idx = word_index(bus.addr, BASE_ADDR);
  assign req_err = !index_in_range(req_idx, word_t'(DEPTH_WORDS)) || (bus.ren && bus.wen);

  // State and latched-request registers.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      wr_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      wr_q    <= wr_d;
      err_q   <= err_d;
    end
  end

  // Next-state logic: accept in IDLE, count down in WAIT, single-cycle RESP.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    wr_d    = wr_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (bus.ren || bus.wen) begin
          idx_d   = req_idx[AW-1:0];
          wdata_d = bus.wdata;
          be_d    = bus.byte_en;
          wr_d    = bus.wen;
          err_d   = req_err;
          cnt_d   = 4'(WAIT_STATES);
          state_d = (WAIT_STATES == 0) ? RESP : WAIT;
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (!bus.ren && !bus.wen) begin
          state_d = IDLE;
        end else if (cnt_q == 4'd1) begin
          state_d = RESP;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Bus outputs and memory write strobe, active only in the completion cycle.
  always_comb begin
    bus.busy  = 1'b1;
    bus.error = 1'b0;
    bus.rdata = '0;
    mem_we    = 1'b0;
    if (state_q == RESP) begin
      bus.busy  = 1'b0;
      bus.error = err_q;
      if (!err_q) begin
        if (wr_q) mem_we = 1'b1;
        else      bus.rdata = mem_rdata;
      end
    end
  end

  generic_bus_mem_array #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .AW         (AW)
  ) u_mem (
    .CLK    (CLK),
    .we     (mem_we),
    .idx    (idx_q),
    .wdata  (wdata_q),
    .byte_en(be_q),
    .rdata  (mem_rdata)
  );

endmodule
